instr_mem_loader: RTL

Byte-stream program loader that writes 32-bit instructions into the core's writable instruction memory. It is the write-side counterpart of the fetch path, which only reads instruction memory by 8-bit byte address. The loader holds the monocycle core in reset while it loads. It accepts a length-prefixed little-endian byte stream over a valid/ready handshake and releases the core once the last word is written.

---
 rtl/RISCV32i_Pack.sv | 28 ++
 rtl/word_assembler.sv | 44 ++++
 rtl/instr_mem_loader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/RISCV32i_Pack.sv
// Shared definitions for the instruction-memory program loader.
// Optional feature: LOADER_CHECKSUM_EN adds a trailing checksum byte (CHK state).
package RISCV32i_Pack;

    // Loader FSM states. CHK is only reachable when LOADER_CHECKSUM_EN is defined.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        CHK    = 3'd5,
        DONE   = 3'd6,
        ERROR  = 3'd7
    } loader_state_t;

    // Number of bytes in the little-endian word-count prefix.
    localparam int LOADER_LEN_BYTES = 2;

    // Bytes per instruction word.
    localparam int WORD_BYTES = 4;

    // Modulo-256 accumulation used by the optional checksum.
    function automatic logic [7:0] byte_sum(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Little-endian word assembler: byte k of a word is inserted at bits [8k+7:8k].
// A 2-bit byte counter tracks the insert position; word_full_o flags a complete word.
// clear_i returns the word, counter and flag to zero (used on entry to DATA).
module word_assembler
    import RISCV32i_Pack::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_data_i,
    output logic [31:0] word_o,
    output logic [1:0]  byte_cnt_o,
    output logic        word_full_o
);

    logic [31:0] word_q;
    logic [1:0]  byte_cnt_q;
    logic        word_full_q;

    // Insert the accepted byte at the current position and advance the counter.
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of its peers, independent of order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            word_q      <= '0;
            byte_cnt_q  <= '0;
            word_full_q <= 1'b0;
        end else if (clear_i) begin
            word_q      <= '0;
            byte_cnt_q  <= '0;
            word_full_q <= 1'b0;
        end else if (byte_en_i) begin
            word_q[{byte_cnt_q, 3'b000} +: 8] <= byte_data_i;
            byte_cnt_q  <= byte_cnt_q + 2'd1;
            word_full_q <= (byte_cnt_q == 2'(WORD_BYTES - 1));
        end
    end

    assign word_o      = word_q;
    assign byte_cnt_o  = byte_cnt_q;
    assign word_full_o = word_full_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-stream program loader for the writable instruction memory.
// Holds the core in reset (core_rst_o=0) while a length-prefixed, little-endian
// stream of 32-bit words is written, then releases it on success.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing modulo-256
// sum of all data bytes before DONE.
module instr_mem_loader
    import RISCV32i_Pack::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH_WORDS = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    output logic                  byte_ready_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  core_rst_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam logic [15:0] MAX_WORDS = 16'(DEPTH_WORDS);

    loader_state_t state_q, state_d;

    // Low count byte(s) held until the high byte arrives.
    logic [8*(LOADER_LEN_BYTES-1)-1:0] len_lo_q;
    logic [15:0]                       len_n;
    logic                              len_bad;

    logic [15:0]           words_left_q;
    logic                  last_word;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic        accept;
    logic        asm_clear;
    logic        asm_en;
    logic [31:0] asm_word;
    logic [1:0]  asm_cnt;
    logic        asm_full;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
`endif

    assign accept    = byte_valid_i && byte_ready_o;
    assign len_n     = {byte_data_i, len_lo_q};
    assign len_bad   = (len_n == 16'd0) || (len_n > MAX_WORDS);
    assign last_word = (words_left_q == 16'd1);

    // The assembler restarts on every entry to DATA: after a valid count and
    // after each WRITE that is not the last word.
    assign asm_en    = accept && (state_q == DATA);
    assign asm_clear = ((state_q == LEN_HI) && accept && !len_bad) ||
                       ((state_q == WRITE) && !last_word);

    word_assembler u_word_assembler (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (asm_clear),
        .byte_en_i   (asm_en),
        .byte_data_i (byte_data_i),
        .word_o      (asm_word),
        .byte_cnt_o  (asm_cnt),
        .word_full_o (asm_full)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    // NOTE: state_d is assigned its hold value first so no path through the
    // case leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = LEN_LO;
            end
            LEN_LO: begin
                if (accept) state_d = LEN_HI;
            end
            LEN_HI: begin
                if (accept) state_d = len_bad ? ERROR : DATA;
            end
            DATA: begin
                if (accept && (asm_cnt == 2'(WORD_BYTES - 1))) state_d = WRITE;
            end
            WRITE: begin
`ifdef LOADER_CHECKSUM_EN
                state_d = last_word ? CHK : DATA;
`else
                state_d = last_word ? DONE : DATA;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) state_d = (byte_data_i == sum_q) ? DONE : ERROR;
            end
`endif
            DONE, ERROR: begin
                if (start_i) state_d = LEN_LO;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state register only; byte_valid_i never reaches them.
    always_comb begin
        byte_ready_o = 1'b0;
        mem_we_o     = 1'b0;
        core_rst_o   = 1'b0;
        done_o       = 1'b0;
        error_o      = 1'b0;
        case (state_q)
            LEN_LO, LEN_HI, DATA: byte_ready_o = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CHK:                  byte_ready_o = 1'b1;
`endif
            WRITE:                mem_we_o     = asm_full;
            DONE: begin
                done_o     = 1'b1;
                core_rst_o = 1'b1;
            end
            ERROR:                error_o      = 1'b1;
            default: ;
        endcase
    end

    // Count capture, remaining-word counter and write address.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            len_lo_q     <= '0;
            words_left_q <= '0;
            addr_q       <= '0;
        end else begin
            if ((state_q == LEN_LO) && accept) len_lo_q <= byte_data_i;
            if ((state_q == LEN_HI) && accept) begin
                words_left_q <= len_n;
                addr_q       <= '0;
            end
            if (state_q == WRITE) begin
                words_left_q <= words_left_q - 16'd1;
                addr_q       <= addr_q + ADDR_WIDTH'(WORD_BYTES);
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running modulo-256 sum of data bytes; count bytes are excluded.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sum_q <= '0;
        end else if ((state_q == LEN_HI) && accept) begin
            sum_q <= '0;
        end else if (asm_en) begin
            sum_q <= byte_sum(sum_q, byte_data_i);
        end
    end
`endif

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = asm_word;

endmodule
